// File: rtl/dshot_pkg.sv
// dshot_pkg: DSHOT speed constants, timing fractions, FSM states and CRC shared by the DSHOT encoder and decoder.
package dshot_pkg;
    localparam int unsigned MODE_150   = 150;
    localparam int unsigned MODE_300   = 300;
    localparam int unsigned MODE_600   = 600;
    localparam int unsigned TH_NUM     = 9;
    localparam int unsigned TH_DEN     = 16;
    localparam int unsigned GLITCH_DEN = 8;
    localparam int unsigned GAP_MULT   = 2;
    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW, ST_FLUSH} rx_state_t;
    function automatic int unsigned period_cycles(input int unsigned hz, input int unsigned mode);
        return hz / (mode * 1000);
    endfunction
    function automatic logic mode_ok(input logic [15:0] m);
        return m == 16'(MODE_150) || m == 16'(MODE_300) || m == 16'(MODE_600);
    endfunction
    function automatic logic [3:0] crc4(input logic [15:0] f);
        return f[15:12] ^ f[11:8] ^ f[7:4];
    endfunction
endpackage

// File: rtl/dshot_rx_decoder_if.sv
// dshot_rx_decoder_if: line, speed select and decoded frame/status bundle for the DSHOT receiver.
interface dshot_rx_decoder_if;
    logic        dshot;
    logic [15:0] dshot_mode;
    logic [15:0] value;
    logic [10:0] throttle;
    logic        telemetry;
    logic        valid;
    logic        crc_err;
    logic        frame_err;
    logic        busy;
    modport master (output dshot, dshot_mode, input value, throttle, telemetry, valid, crc_err, frame_err, busy);
    modport slave (input dshot, dshot_mode, output value, throttle, telemetry, valid, crc_err, frame_err, busy);
endinterface

// File: rtl/dshot_input_sync.sv
// dshot_input_sync: 2-FF synchroniser for the asynchronous DSHOT line with rise/fall pulses on the synchronised level.
module dshot_input_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic s1, prev;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {s1, level, prev} <= '0;
        else {s1, level, prev} <= {din, s1, level};
    assign rise = level & ~prev;
    assign fall = ~level & prev;
endmodule

// File: rtl/dshot_rx_decoder.sv
// dshot_rx_decoder: measures DSHOT bit high times against the latched speed, assembles 16-bit frames and checks the CRC.
module dshot_rx_decoder
    import dshot_pkg::*;
#(
    parameter int unsigned clock_frequency = 72_000_000
) (
    input logic clk,
    input logic rst_n,
    dshot_rx_decoder_if.slave bus
);
    localparam int unsigned P150 = period_cycles(clock_frequency, MODE_150);
    localparam int unsigned P300 = period_cycles(clock_frequency, MODE_300);
    localparam int unsigned P600 = period_cycles(clock_frequency, MODE_600);
    localparam int unsigned CW = $clog2(GAP_MULT * P150 + 1);
    typedef logic [CW-1:0] cnt_t;

    rx_state_t state_q, state_d;
    cnt_t cnt_q, cnt_d, p_q, p_d, th_q, th_d, g_q, g_d, cnt_inc, sel_p, sel_th, sel_g;
    logic [3:0] bits_q, bits_d;
    logic [15:0] sr_q, sr_d, value_d;
    logic valid_d, crc_d, ferr_d, busy_d, level, rise, fall, m150, m300;
    logic [CW:0] cnt_next, gap_lim;

    dshot_input_sync u_sync (.clk(clk), .rst_n(rst_n), .din(bus.dshot), .level(level), .rise(rise), .fall(fall));

    assign m150     = bus.dshot_mode == 16'(MODE_150);
    assign m300     = bus.dshot_mode == 16'(MODE_300);
    assign sel_p    = m150 ? cnt_t'(P150) : m300 ? cnt_t'(P300) : cnt_t'(P600);
    assign sel_th   = m150 ? cnt_t'(P150 * TH_NUM / TH_DEN) : m300 ? cnt_t'(P300 * TH_NUM / TH_DEN) : cnt_t'(P600 * TH_NUM / TH_DEN);
    assign sel_g    = m150 ? cnt_t'(P150 / GLITCH_DEN) : m300 ? cnt_t'(P300 / GLITCH_DEN) : cnt_t'(P600 / GLITCH_DEN);
    assign cnt_inc  = &cnt_q ? cnt_q : cnt_q + 1'b1;
    // value the counter will hold after this cycle, compared against the limits so they fire on reaching them
    assign cnt_next = {1'b0, cnt_q} + 1'b1;
    assign gap_lim  = (CW+1)'(GAP_MULT * p_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        bits_d  = bits_q;
        sr_d    = sr_q;
        p_d     = p_q;
        th_d    = th_q;
        g_d     = g_q;
        value_d = bus.value;
        valid_d = 1'b0;
        crc_d   = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (rise && mode_ok(bus.dshot_mode)) begin
                state_d = ST_HIGH;
                cnt_d   = cnt_t'(1);
                bits_d  = '0;
                p_d     = sel_p;
                th_d    = sel_th;
                g_d     = sel_g;
            end
            ST_HIGH: if (fall) begin
                if (cnt_q < g_q) begin
                    ferr_d  = 1'b1;
                    state_d = ST_FLUSH;
                end else begin
                    sr_d    = {sr_q[14:0], cnt_q >= th_q};
                    bits_d  = bits_q + 4'd1;
                    state_d = bits_q == 4'd15 ? ST_IDLE : ST_LOW;
                    valid_d = bits_q == 4'd15 && crc4(sr_d) == sr_d[3:0];
                    crc_d   = bits_q == 4'd15 && crc4(sr_d) != sr_d[3:0];
                    value_d = valid_d ? sr_d : bus.value;
                end
            end else if (cnt_next >= {1'b0, p_q}) begin
                ferr_d  = 1'b1;
                state_d = ST_FLUSH;
            end
            ST_LOW: if (rise) begin
                state_d = ST_HIGH;
                cnt_d   = cnt_t'(1);
            end else if (cnt_next >= gap_lim) begin
                ferr_d  = 1'b1;
                state_d = ST_FLUSH;
            end
            ST_FLUSH: state_d = level ? ST_FLUSH : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = state_d == ST_HIGH || state_d == ST_LOW;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bits_q        <= '0;
            sr_q          <= '0;
            p_q           <= '0;
            th_q          <= '0;
            g_q           <= '0;
            bus.value     <= '0;
            bus.valid     <= 1'b0;
            bus.crc_err   <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bits_q        <= bits_d;
            sr_q          <= sr_d;
            p_q           <= p_d;
            th_q          <= th_d;
            g_q           <= g_d;
            bus.value     <= value_d;
            bus.valid     <= valid_d;
            bus.crc_err   <= crc_d;
            bus.frame_err <= ferr_d;
            bus.busy      <= busy_d;
        end

    assign bus.throttle  = bus.value[15:5];
    assign bus.telemetry = bus.value[4];
endmodule

// File: tb/tb_dshot_rx_decoder.sv
// tb_dshot_rx_decoder: directed DSHOT frames at each speed, CRC/gap faults and mid-frame reset with hand-computed expectations.
module tb_dshot_rx_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    int n_valid = 0;
    int n_crc = 0;
    int n_ferr = 0;
    int v0, c0, f0;

    dshot_rx_decoder_if bus ();
    dshot_rx_decoder #(.clock_frequency(72_000_000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.valid) n_valid += 1;
        if (bus.crc_err) n_crc += 1;
        if (bus.frame_err) n_ferr += 1;
    end

    function automatic int period(input int mode);
        return 72_000_000 / (mode * 1000);
    endfunction

    task automatic send_bits(input logic [15:0] f, input int n, input int mode);
        int p, hi;
        p = period(mode);
        for (int i = 0; i < n; i++) begin
            hi = f[15-i] ? p * 3 / 4 : p * 3 / 8;
            bus.dshot = 1'b1;
            repeat (hi) @(negedge clk);
            bus.dshot = 1'b0;
            repeat (p - hi) @(negedge clk);
        end
    endtask

    task automatic snap();
        v0 = n_valid;
        c0 = n_crc;
        f0 = n_ferr;
    endtask

    task automatic check_good(input string name, input logic [15:0] exp);
        total += 4;
        if (n_valid - v0 !== 1) begin bad++; $display("FAIL %s valid pulses got=%0d want=1", name, n_valid - v0); end
        if (bus.value !== exp) begin bad++; $display("FAIL %s value got=%h want=%h", name, bus.value, exp); end
        if (bus.throttle !== exp[15:5]) begin bad++; $display("FAIL %s throttle got=%h want=%h", name, bus.throttle, exp[15:5]); end
        if (bus.telemetry !== exp[4] || n_crc != c0 || n_ferr != f0) begin
            bad++;
            $display("FAIL %s telem/err got=%b,%0d,%0d want=%b,0,0", name, bus.telemetry, n_crc - c0, n_ferr - f0, exp[4]);
        end
    endtask

    task automatic test_reset();
        bus.dshot = 1'b0;
        bus.dshot_mode = 16'd150;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        total += 3;
        if (bus.value !== 16'h0 || bus.throttle !== 11'h0 || bus.telemetry !== 1'b0) begin bad++; $display("FAIL reset value got=%h want=0000", bus.value); end
        if (bus.valid !== 1'b0 || bus.crc_err !== 1'b0 || bus.frame_err !== 1'b0) begin bad++; $display("FAIL reset pulses got=%b%b%b want=000", bus.valid, bus.crc_err, bus.frame_err); end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b want=0", bus.busy); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_zero_150();
        bus.dshot_mode = 16'd150;
        snap();
        send_bits(16'h0000, 16, 150);
        repeat (10) @(negedge clk);
        check_good("zero150", 16'h0000);
    endtask

    task automatic test_bad_mode();
        bus.dshot_mode = 16'd200;
        snap();
        send_bits(16'hFFFF, 16, 300);
        repeat (10) @(negedge clk);
        total += 2;
        if (n_valid != v0 || n_crc != c0 || n_ferr != f0) begin bad++; $display("FAIL badmode pulses got=%0d,%0d,%0d want=0,0,0", n_valid - v0, n_crc - c0, n_ferr - f0); end
        if (bus.value !== 16'h0000) begin bad++; $display("FAIL badmode value got=%h want=0000", bus.value); end
    endtask

    task automatic test_ones();
        bus.dshot_mode = 16'd300;
        snap();
        send_bits(16'hFFFF, 16, 300);
        repeat (10) @(negedge clk);
        check_good("ones300", 16'hFFFF);
        bus.dshot_mode = 16'd600;
        snap();
        send_bits(16'hFFFF, 16, 600);
        repeat (10) @(negedge clk);
        check_good("ones600", 16'hFFFF);
        total++;
        if (bus.throttle !== 11'h7FF) begin bad++; $display("FAIL ones throttle got=%h want=7ff", bus.throttle); end
    endtask

    task automatic test_mode_switch();
        bus.dshot_mode = 16'd600;
        repeat (20) @(negedge clk);
        bus.dshot_mode = 16'd150;
        snap();
        send_bits(16'h5555, 16, 150);
        repeat (10) @(negedge clk);
        check_good("switch150", 16'h5555);
    endtask

    task automatic test_crc_err();
        bus.dshot_mode = 16'd600;
        snap();
        send_bits(16'hFFF0, 16, 600);
        repeat (10) @(negedge clk);
        total += 3;
        if (n_crc - c0 !== 1) begin bad++; $display("FAIL crc pulses got=%0d want=1", n_crc - c0); end
        if (n_valid != v0 || n_ferr != f0) begin bad++; $display("FAIL crc other got=%0d,%0d want=0,0", n_valid - v0, n_ferr - f0); end
        if (bus.value !== 16'h5555) begin bad++; $display("FAIL crc value got=%h want=5555", bus.value); end
    endtask

    task automatic test_reset_mid();
        bus.dshot_mode = 16'd300;
        snap();
        send_bits(16'hFFFF, 9, 300);
        bus.dshot = 1'b1;
        repeat (30) @(negedge clk);
        total++;
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL midrst busy before got=%b want=1", bus.busy); end
        rst_n = 1'b0;
        #1;
        total += 2;
        if (bus.value !== 16'h0 || bus.busy !== 1'b0) begin bad++; $display("FAIL midrst outputs got=%h,%b want=0000,0", bus.value, bus.busy); end
        if (bus.valid !== 1'b0 || bus.crc_err !== 1'b0 || bus.frame_err !== 1'b0) begin bad++; $display("FAIL midrst pulses got=%b%b%b want=000", bus.valid, bus.crc_err, bus.frame_err); end
        bus.dshot = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (n_valid != v0 || n_crc != c0 || n_ferr != f0) begin bad++; $display("FAIL midrst no pulse got=%0d,%0d,%0d want=0,0,0", n_valid - v0, n_crc - c0, n_ferr - f0); end
        snap();
        send_bits(16'h1230, 16, 300);
        repeat (10) @(negedge clk);
        check_good("after_rst", 16'h1230);
        total++;
        if (bus.throttle !== 11'h091) begin bad++; $display("FAIL after_rst throttle got=%h want=091", bus.throttle); end
    endtask

    task automatic test_gap_timeout();
        bus.dshot_mode = 16'd300;
        snap();
        send_bits(16'hA5A5, 8, 300);
        total++;
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL gap busy mid got=%b want=1", bus.busy); end
        repeat (600) @(negedge clk);
        total += 3;
        if (n_ferr - f0 !== 1) begin bad++; $display("FAIL gap frame_err pulses got=%0d want=1", n_ferr - f0); end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL gap busy got=%b want=0", bus.busy); end
        if (n_valid != v0 || n_crc != c0 || bus.value !== 16'h1230) begin bad++; $display("FAIL gap other got=%0d,%0d,%h want=0,0,1230", n_valid - v0, n_crc - c0, bus.value); end
        snap();
        send_bits(16'h0000, 16, 300);
        repeat (10) @(negedge clk);
        check_good("gap_recover", 16'h0000);
    endtask

    task automatic test_back_to_back();
        bus.dshot_mode = 16'd600;
        snap();
        send_bits(16'h5555, 16, 600);
        send_bits(16'hFFFF, 16, 600);
        repeat (10) @(negedge clk);
        total += 2;
        if (n_valid - v0 !== 2) begin bad++; $display("FAIL b2b valid pulses got=%0d want=2", n_valid - v0); end
        if (bus.value !== 16'hFFFF) begin bad++; $display("FAIL b2b value got=%h want=ffff", bus.value); end
    endtask

    initial begin
        test_reset();
        test_zero_150();
        test_bad_mode();
        test_ones();
        test_mode_switch();
        test_crc_err();
        test_reset_mid();
        test_gap_timeout();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dshot_rx_decoder.md
# dshot_rx_decoder

Receive-side DSHOT decoder: samples one asynchronous DSHOT line, measures the high time of each bit against the programmed speed (DSHOT150/300/600), assembles 16-bit frames, checks the 4-bit CRC and presents throttle/telemetry fields with a one-cycle valid strobe. It is the loopback checker for `dshot_output` on the bench and the capture path for sniffing an external flight controller's motor line.

## Interface
- `clockFrequency`, 72_000_000, system clock in Hz; all bit timing is derived from it.
- `i_clk` in 1 system clock.
- `i_reset_n` in 1 asynchronous, active-low reset.
- `i_dshot` in 1 raw DSHOT line, asynchronous to `i_clk`.
- `i_dshot_mode` in 16 speed select: 150, 300 or 600 (decimal); any other value disables decoding.
- `o_value` out 16 last good frame, MSB first as received.
- `o_throttle` out 11 `o_value[15:5]`.
- `o_telemetry` out 1 `o_value[4]`.
- `o_valid` out 1 one-cycle pulse: new good frame on `o_value`.
- `o_crc_err` out 1 one-cycle pulse: 16 bits received, CRC mismatch; `o_value` unchanged.
- `o_frame_err` out 1 one-cycle pulse: frame aborted (glitch, over-long high, gap timeout).
- `o_busy` out 1 high while a frame is in progress.

## Operation
- Input: 2-FF synchroniser plus edge detector on `i_dshot`; all decisions use the synchronised signal.
- Bit period `P = clockFrequency / (mode*1000)` cycles; threshold `TH = P*9/16` (floor); glitch limit `G = P/8`; gap limit `2*P`. At 72 MHz: 150→P=480, TH=270; 300→P=240, TH=135; 600→P=120, TH=67.
- Mode sampled and P/TH/G latched on the first rising edge of a frame; changes to `i_dshot_mode` mid-frame take effect at the next frame.
- FSM states: IDLE, HIGH, LOW, FLUSH.
  - IDLE: wait for rising edge with supported mode → HIGH, bit count 0, high counter 1. Unsupported mode: stay IDLE, ignore line.
  - HIGH: count cycles. Falling edge: count < G → frame error; count ≥ TH → bit 1, else bit 0; shift in MSB-first. 16th bit → evaluate, IDLE; else → LOW. Count reaching P while still high → frame error.
  - LOW: count cycles since rising edge of current bit. Rising edge → HIGH. Count reaching 2*P → frame error.
  - FLUSH (after any frame error): wait until line low, then IDLE.
- CRC: `crc = f[15:12] ^ f[11:8] ^ f[7:4]`; good iff equal to `f[3:0]`. Good → update `o_value`, pulse `o_valid`; bad → pulse `o_crc_err`.
- Counters sized for 2*P at DSHOT150 (≥10 bits at 72 MHz), saturating.

## Timing
- Reset values: `o_value`=0, `o_throttle`=0, `o_telemetry`=0, `o_valid`=0, `o_crc_err`=0, `o_frame_err`=0, `o_busy`=0, FSM IDLE, synchroniser flops 0.
- Pin-to-edge latency 2 cycles; `o_valid`/`o_crc_err` asserted on the cycle after the 16th falling edge is detected (3 cycles after the pin falls), high exactly one cycle.
- `o_value`, `o_throttle`, `o_telemetry` change in the same cycle `o_valid` rises and hold until the next good frame.
- `o_busy` rises the cycle the first rising edge is detected, falls with the status pulse or on entry to FLUSH.
- Frame error pulse: one cycle, on the cycle the fault is detected.
- Reset asserted mid-frame: immediate return to reset values; partial frame discarded, no pulse.
- Back-to-back frames: next frame's rising edge accepted the cycle after returning to IDLE.
- Measurement resolution ±1 cycle; high times within TH±1 are undefined-decision territory and not tested.

## Structure
- Shared package `dshot_pkg`: supported mode constants (150/300/600), threshold fraction (9/16), glitch fraction (1/8), gap multiple (2), CRC function; shared with `dshot_output`.
- Sub-module `dshot_input_sync`: 2-FF synchroniser plus rise/fall pulse outputs.

## Test plan
- DSHOT150, transmit 0x0000 via `dshot_output` looped to `i_dshot` → one `o_valid`, `o_value`=0x0000, `o_throttle`=0, no error pulses.
- DSHOT300 then DSHOT600, transmit 0xFFFF → `o_valid` each, `o_value`=0xFFFF, `o_throttle`=0x7FF, `o_telemetry`=1.
- Mode switched 600→150 between frames, transmit 0x5555 → `o_valid`, `o_value`=0x5555.
- DSHOT600, drive frame 0xFFF0 by hand → `o_crc_err` pulse, `o_value` retains 0x5555.
- DSHOT300, 8 bits then line low for 600 cycles → `o_frame_err` pulse, `o_busy` low; following good 0x0000 frame decodes.
- Assert `i_reset_n` low during bit 10 of a frame → all outputs 0, no pulses; next frame decodes normally.
